ov7670_sccb_controller: RTL

OV7670_SCCB_CONTROLLER -- requirements
Module: ov7670_sccb_controller

---
 rtl/ov7670_sccb_controller.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ov7670_sccb_controller.sv
// OV7670 SCCB configuration sequencer: walks an external register table and
// issues one 3-phase SCCB write per entry, with a long settle after a soft reset.
module ov7670_sccb_controller #(
    parameter int          CLK_DIV    = 250,
    parameter logic [7:0]  DEVICE_ID  = 8'h42,
    parameter int          RESET_WAIT = 100000,
    parameter int          BUS_FREE   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] command,
    input  logic        finished,
    output logic        resend,
    output logic        advance,
    output logic        sioc,
    output logic        siod_out,
    output logic        siod_oe,
    output logic        busy,
    output logic        done
);

    // state  | meaning
    // IDLE   | bus idle, waiting for start
    // REWIND | resend pulse, table back to entry 0
    // FETCH  | wait for table data, then sample command/finished
    // START  | SCCB start condition (2 ticks)
    // BITS   | 27 bits: ID, register, value (9th bit released)
    // STOP   | SCCB stop condition (3 ticks)
    // GAP    | bus free time after stop
    // HOLD   | settle time after a sensor soft reset
    // STEP   | advance pulse, table to next entry
    // DONE   | pass complete, bus idle, waiting for start
    typedef enum logic [3:0] {
        IDLE, REWIND, FETCH, START, BITS, STOP, GAP, HOLD, STEP, DONE
    } state_t;

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int HOLD_W = (RESET_WAIT > 1) ? $clog2(RESET_WAIT) : 1;
    localparam int GAP_W  = (BUS_FREE > 1) ? $clog2(BUS_FREE) : 1;

    state_t              state;
    logic [DIV_W-1:0]    div_cnt;
    logic [1:0]          qtr;
    logic [3:0]          bit_cnt;
    logic [1:0]          byte_cnt;
    logic [7:0]          shreg;
    logic [15:0]         cmd_q;
    logic                fetch_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [HOLD_W-1:0]   hold_cnt;

    logic       tick;
    logic       hold_needed;
    logic [7:0] next_byte;

    assign tick        = (div_cnt == '0);
    assign hold_needed = (cmd_q[15:8] == 8'h12) && cmd_q[7];
    assign next_byte   = (byte_cnt == 2'd0) ? cmd_q[15:8] : cmd_q[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sioc      <= 1'b1;
            siod_out  <= 1'b1;
            siod_oe   <= 1'b1;
            resend    <= 1'b0;
            advance   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_cnt   <= '0;
            qtr       <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
            cmd_q     <= '0;
            fetch_cnt <= 1'b0;
            gap_cnt   <= '0;
            hold_cnt  <= '0;
        end else begin
            resend  <= 1'b0;
            advance <= 1'b0;
            div_cnt <= tick ? DIV_W'(CLK_DIV - 1) : div_cnt - 1'b1;

            case (state)
                IDLE, DONE: begin
                    sioc     <= 1'b1;
                    siod_out <= 1'b1;
                    siod_oe  <= 1'b1;
                    if (start) begin
                        state  <= REWIND;
                        resend <= 1'b1;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                REWIND: begin
                    state     <= FETCH;
                    fetch_cnt <= 1'b1;
                end
                FETCH: begin
                    if (fetch_cnt) begin
                        fetch_cnt <= 1'b0;
                    end else if (finished) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        // divider restarts here so every bus edge lands on a tick
                        cmd_q    <= command;
                        state    <= START;
                        siod_out <= 1'b0;
                        div_cnt  <= DIV_W'(CLK_DIV - 1);
                        qtr      <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (qtr == 2'd0) begin
                            sioc <= 1'b0;
                            qtr  <= 2'd1;
                        end else begin
                            state    <= BITS;
                            qtr      <= '0;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                            siod_oe  <= 1'b1;
                            siod_out <= DEVICE_ID[7];
                            shreg    <= {DEVICE_ID[6:0], 1'b0};
                        end
                    end
                end
                BITS: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        if (qtr == 2'd1) sioc <= 1'b1;
                        if (qtr == 2'd3) begin
                            sioc <= 1'b0;
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= '0;
                                siod_oe <= 1'b1;
                                if (byte_cnt == 2'd2) begin
                                    state    <= STOP;
                                    byte_cnt <= '0;
                                    siod_out <= 1'b0;
                                end else begin
                                    byte_cnt <= byte_cnt + 2'd1;
                                    siod_out <= next_byte[7];
                                    shreg    <= {next_byte[6:0], 1'b0};
                                end
                            end else if (bit_cnt == 4'd7) begin
                                bit_cnt  <= 4'd8;
                                siod_oe  <= 1'b0;
                                siod_out <= 1'b1;
                            end else begin
                                bit_cnt  <= bit_cnt + 4'd1;
                                siod_out <= shreg[7];
                                shreg    <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        if (qtr == 2'd0) sioc <= 1'b1;
                        if (qtr == 2'd1) siod_out <= 1'b1;
                        if (qtr == 2'd2) begin
                            // a BUS_FREE of 0 still yields a one-tick gap
                            state   <= GAP;
                            qtr     <= '0;
                            gap_cnt <= GAP_W'((BUS_FREE > 0) ? BUS_FREE - 1 : 0);
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end else if (hold_needed) begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_W'((RESET_WAIT > 0) ? RESET_WAIT - 1 : 0);
                        end else begin
                            state   <= STEP;
                            advance <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else begin
                        state   <= STEP;
                        advance <= 1'b1;
                    end
                end
                STEP: begin
                    state     <= FETCH;
                    fetch_cnt <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
